// File: rtl/pooling_average_ctrl.sv
// Sequencer for the global-average-pooling accumulator BRAM datapath.
// Takes 32-bit IFM words (4 x 8-bit channels) and, for every word, issues four
// BRAM reads and four read-modify-writes, one per channel byte. The BRAM read
// latency is RD_LAT cycles. When all spatial positions are summed, it walks the
// channel groups out to the SE stage.
//
// Handshakes (both ports):
//   A transfer happens on a rising clock edge where valid and ready are both high.
//   A source holds its payload stable while valid is high until that transfer.
//   in_valid/in_ready:   the controller raises in_ready only in ACCUM with no
//                        word in flight, or in the cycle of the in-flight word's
//                        final write.
//   out_valid/out_ready: out_valid and read_addr hold until out_ready is seen.
// dbg_state exposes the FSM state encoding: 0 IDLE, 1 ACCUM, 2 READOUT, 3 DONE.
module pooling_average_ctrl #(
    parameter int NUM_CH  = 32,
    parameter int NUM_PIX = 196,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        valid,
    output logic [1:0]  control_data,
    output logic [31:0] read_addr,
    output logic [31:0] write_addr,
    output logic        we,
    output logic        init_phase,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam int NUM_GRP = NUM_CH / 4;
    localparam int GW      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int PW      = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

    localparam logic [GW-1:0] G_LAST    = GW'(NUM_GRP - 1);
    localparam logic [PW-1:0] P_LAST    = PW'(NUM_PIX - 1);
    // Per-word schedule: step s issues read k=s (s<=3) and write k=s-RD_LAT.
    localparam logic [2:0]    LAT       = 3'(RD_LAT);
    localparam logic [2:0]    LAST_STEP = 3'(3 + RD_LAT);
    localparam logic [1:0]    WAIT_INIT = 2'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_READOUT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [GW-1:0] g_cnt;     // group of the next word to accept
    logic [PW-1:0] p_cnt;     // pixel of the next word to accept
    logic [GW-1:0] cur_g;     // group of the word in flight
    logic [PW-1:0] cur_p;     // pixel of the word in flight
    logic          fly;       // a word is being read/written
    logic [2:0]    step;      // schedule step of the word in flight
    logic [GW-1:0] rd_g;      // group being presented to SE
    logic [1:0]    rd_wait;   // cycles until readout data is valid

    logic          accept;
    logic          cur_last;
    logic          last_write;

    logic          n_fly;
    logic [2:0]    n_step;
    logic [GW-1:0] n_g;
    logic [PW-1:0] n_p;
    logic [1:0]    n_k;
    logic          n_we;
    logic          n_last;

    assign accept     = (state == S_ACCUM) && in_valid && in_ready;
    assign valid      = in_valid & in_ready;
    assign cur_last   = (cur_p == P_LAST) && (cur_g == G_LAST);
    assign last_write = fly && (step == LAST_STEP) && cur_last;
    assign dbg_state  = state;

    function automatic logic [31:0] addr_of(input logic [GW-1:0] g, input logic [1:0] k);
        return 32'({g, k});
    endfunction

    // Schedule position of the word that will be in flight next cycle.
    always_comb begin
        n_fly  = 1'b0;
        n_step = step;
        n_g    = cur_g;
        n_p    = cur_p;
        if (accept) begin
            n_fly  = 1'b1;
            n_step = 3'd0;
            n_g    = g_cnt;
            n_p    = p_cnt;
        end else if (fly && (step != LAST_STEP)) begin
            n_fly  = 1'b1;
            n_step = step + 3'd1;
        end
        n_k    = 2'(n_step - LAT);
        n_we   = (n_step >= LAT);
        n_last = (n_p == P_LAST) && (n_g == G_LAST);
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            g_cnt        <= '0;
            p_cnt        <= '0;
            cur_g        <= '0;
            cur_p        <= '0;
            fly          <= 1'b0;
            step         <= 3'd0;
            rd_g         <= '0;
            rd_wait      <= 2'd0;
            in_ready     <= 1'b0;
            control_data <= 2'd0;
            read_addr    <= 32'd0;
            write_addr   <= 32'd0;
            we           <= 1'b0;
            init_phase   <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACCUM;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        g_cnt    <= '0;
                        p_cnt    <= '0;
                        fly      <= 1'b0;
                        step     <= 3'd0;
                    end
                end

                S_ACCUM: begin
                    if (accept) begin
                        if (g_cnt == G_LAST) begin
                            g_cnt <= '0;
                            p_cnt <= p_cnt + 1'b1;
                        end else begin
                            g_cnt <= g_cnt + 1'b1;
                        end
                    end
                    if (last_write) begin
                        // Final channel of the frame written: start the readout walk.
                        state        <= S_READOUT;
                        fly          <= 1'b0;
                        we           <= 1'b0;
                        control_data <= 2'd0;
                        init_phase   <= 1'b0;
                        in_ready     <= 1'b0;
                        rd_g         <= '0;
                        read_addr    <= 32'd0;
                        out_valid    <= (RD_LAT == 0);
                        rd_wait      <= WAIT_INIT;
                    end else begin
                        fly   <= n_fly;
                        step  <= n_step;
                        cur_g <= n_g;
                        cur_p <= n_p;
                        if (n_fly) begin
                            if (n_step <= 3'd3)
                                read_addr <= addr_of(n_g, n_step[1:0]);
                            we <= n_we;
                            if (n_we) begin
                                write_addr   <= addr_of(n_g, n_k);
                                control_data <= n_k;
                                init_phase   <= (n_p == '0);
                            end else begin
                                control_data <= 2'd0;
                                init_phase   <= 1'b0;
                            end
                            // The next word may be latched during the final write,
                            // except after the last word of the frame.
                            in_ready <= (n_step == LAST_STEP) && !n_last;
                        end else begin
                            we           <= 1'b0;
                            control_data <= 2'd0;
                            init_phase   <= 1'b0;
                            in_ready     <= 1'b1;
                        end
                    end
                end

                S_READOUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_g == G_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            rd_g      <= rd_g + 1'b1;
                            read_addr <= addr_of(rd_g + 1'b1, 2'd0);
                            out_valid <= (RD_LAT == 0);
                            rd_wait   <= WAIT_INIT;
                        end
                    end else if (!out_valid) begin
                        if (rd_wait <= 2'd1)
                            out_valid <= 1'b1;
                        else
                            rd_wait <= rd_wait - 2'd1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pooling_average_ctrl.sv
// Bench for pooling_average_ctrl (NUM_CH=32, NUM_PIX=196, RD_LAT=1).
// A small harness plays the accumulator datapath: an IFM register, a BRAM with
// one-cycle read latency, and an adder driven purely by the controller's outputs.
// A reference model computes each channel's sum over all pixels and the expected
// write sequence for every accepted word.
module tb_pooling_average_ctrl;

    localparam int NUM_CH  = 32;
    localparam int NUM_PIX = 196;
    localparam int RD_LAT  = 1;
    localparam int NUM_GRP = NUM_CH / 4;
    localparam int AW      = $clog2(NUM_CH);
    localparam int W       = 35;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] data_in;
    logic        in_ready;
    logic        valid;
    logic [1:0]  control_data;
    logic [31:0] read_addr;
    logic [31:0] write_addr;
    logic        we;
    logic        init_phase;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // clock / reset block
    always #5 clk = ~clk;

    pooling_average_ctrl #(
        .NUM_CH (NUM_CH),
        .NUM_PIX(NUM_PIX),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .valid       (valid),
        .control_data(control_data),
        .read_addr   (read_addr),
        .write_addr  (write_addr),
        .we          (we),
        .init_phase  (init_phase),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // harness datapath and reference model state
    logic [31:0]  mem [NUM_CH];
    logic [31:0]  rd_q;
    logic [31:0]  ifm_reg;
    logic [W-1:0] exp_q[$];
    int           exp_sum [NUM_CH];
    int           cyc      = 0;
    int           last_hs  = 0;
    int           frame_hs = 0;
    int           hs_p     = 0;
    int           hs_g     = 0;
    int           acc_cnt  = 0;
    int           done_cnt = 0;
    bit           spacing_chk = 1'b0;
    bit           prev_acc    = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[8*int'(k) +: 8];
    endfunction

    // scoreboard / harness: evaluates each cycle's effects at the falling edge
    always @(negedge clk) begin
        logic [31:0]  new_rd;
        logic [W-1:0] e;
        cyc++;
        if (!reset) begin
            chk("valid_is_handshake", 64'(valid), 64'(in_valid & in_ready));
            if (prev_acc) chk("out_valid_gap_after_accept", 64'(out_valid), 64'd0);
            prev_acc = 1'b0;
            new_rd = (read_addr < NUM_CH) ? mem[read_addr[AW-1:0]] : 32'hdead_beef;
            if (we) begin
                if (exp_q.size() == 0) begin
                    chk("we_unexpected", 64'(we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_seq", 64'({init_phase, control_data, write_addr}), 64'(e));
                    if (write_addr < NUM_CH)
                        mem[write_addr[AW-1:0]] = (init_phase ? 32'd0 : rd_q)
                                                  + 32'(byte_of(ifm_reg, control_data));
                end
            end
            rd_q = new_rd;
            if (in_valid && in_ready) begin
                if (spacing_chk && frame_hs > 0)
                    chk("in_ready_spacing", 64'(cyc - last_hs), 64'(4 + RD_LAT));
                last_hs = cyc;
                frame_hs++;
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({(hs_p == 0), 2'(k), 32'(4 * hs_g + k)});
                ifm_reg = data_in;
                if (hs_g == NUM_GRP - 1) begin
                    hs_g = 0;
                    hs_p++;
                end else begin
                    hs_g++;
                end
            end
            if (out_valid && out_ready) begin
                chk("readout_addr", 64'(read_addr), 64'(4 * acc_cnt));
                if (acc_cnt < NUM_GRP) begin
                    for (int k = 0; k < 4; k++)
                        chk("readout_sum", 64'(mem[AW'(4 * acc_cnt + k)]),
                            64'(exp_sum[4 * acc_cnt + k]));
                end else begin
                    chk("readout_extra_group", 64'(acc_cnt), 64'(NUM_GRP - 1));
                end
                acc_cnt++;
                prev_acc = 1'b1;
            end
            if (done) begin
                done_cnt++;
                chk("done_after_last_group", 64'(acc_cnt), 64'(NUM_GRP));
                chk("done_busy", 64'(busy), 64'd1);
                chk("done_no_pending_writes", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    // driver tasks
    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"},     64'(in_ready),     64'd0);
        chk({tag, "_valid"},        64'(valid),        64'd0);
        chk({tag, "_control_data"}, 64'(control_data), 64'd0);
        chk({tag, "_read_addr"},    64'(read_addr),    64'd0);
        chk({tag, "_write_addr"},   64'(write_addr),   64'd0);
        chk({tag, "_we"},           64'(we),           64'd0);
        chk({tag, "_init_phase"},   64'(init_phase),   64'd0);
        chk({tag, "_out_valid"},    64'(out_valid),    64'd0);
        chk({tag, "_busy"},         64'(busy),         64'd0);
        chk({tag, "_done"},         64'(done),         64'd0);
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int c = 0; c < NUM_CH; c++) exp_sum[c] = 0;
        hs_p = 0; hs_g = 0; acc_cnt = 0; done_cnt = 0; frame_hs = 0; prev_acc = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_in_ready", 64'(in_ready), 64'd1);
    endtask

    // mode 0: random bytes; otherwise every byte is cb
    task automatic send_words(input int mode, input logic [7:0] cb, input int nwords,
                              input bit gaps);
        logic [31:0] word;
        bit          accepted;
        int          waited;
        spacing_chk = !gaps;
        for (int i = 0; i < nwords; i++) begin
            word = (mode == 0) ? $urandom : {4{cb}};
            for (int k = 0; k < 4; k++)
                exp_sum[4 * (i % NUM_GRP) + k] += int'(word[8*k +: 8]);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            data_in  = word;
            start    = (i == 100);
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 40) begin
                @(negedge clk);
                accepted = in_ready;
                @(posedge clk);
                #1;
                start = 1'b0;
                waited++;
            end
            if (!accepted) chk("in_ready_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_readout(input bit stall);
        int stall_n = 0;
        int n = 0;
        in_valid = 1'b1;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            data_in = $urandom;
            if (stall && acc_cnt == 3 && stall_n < 7 && (out_valid || stall_n > 0)) begin
                if (stall_n > 0) chk("stall_out_valid_held", 64'(out_valid), 64'd1);
                chk("stall_read_addr", 64'(read_addr), 64'd12);
                out_ready = 1'b0;
                stall_n++;
                start = (stall_n == 3);
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                start     = 1'b0;
            end
        end
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        if (stall) chk("stall_cycles", 64'(stall_n), 64'd7);
        // Now in the cycle after DONE.
        chk("post_done_busy", 64'(busy), 64'd0);
        chk("post_done_done", 64'(done), 64'd0);
        chk("post_done_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("groups_accepted", 64'(acc_cnt), 64'(NUM_GRP));
        chk("words_accepted", 64'(frame_hs), 64'(NUM_PIX * NUM_GRP));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // in_valid and ready-side activity while IDLE must have no effect
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        data_in  = 32'h1234_5678;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", 64'(in_ready), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // frame A: random bytes, continuous input, readout stalled on group 3
        do_start();
        send_words(0, 8'h00, NUM_PIX * NUM_GRP, 1'b0);
        run_readout(1'b1);

        // frame B: all 0xFF with bursty input
        do_start();
        send_words(1, 8'hFF, NUM_PIX * NUM_GRP, 1'b1);
        run_readout(1'b0);

        // frame C: all 0x02; init_phase must discard frame B values (sums 392)
        do_start();
        send_words(1, 8'h02, NUM_PIX * NUM_GRP, 1'b0);
        chk("frame_c_sum_ch0", 64'(exp_sum[0]), 64'd392);
        run_readout(1'b0);

        // frame D: reset asserted mid-accumulation at pixel 50
        do_start();
        send_words(1, 8'h07, 50 * NUM_GRP + 3, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // frame E: all 0x03 after the reset (sums 588)
        do_start();
        send_words(1, 8'h03, NUM_PIX * NUM_GRP, 1'b0);
        chk("frame_e_sum_ch31", 64'(exp_sum[NUM_CH - 1]), 64'd588);
        run_readout(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
